tone_meter: RTL and testbench

- Measures the period of an incoming square-wave tone, reports it as a clock-cycle count, and flags silence (mute) and frequency lock.
- It is the receiving end of the tone divider chain in the game's music path. A divider turns a DIVISOR into a square wave; this block recovers the DIVISOR from the wave.
- Used by the game logic to check which note is playing and whether the output is silent.

---
 rtl/tone_meter.sv | 129 ++++++++++++
 tb/tb_tone_meter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/tone_meter.sv
// Recovers the period of a square-wave tone as a clock-cycle count and flags mute and frequency lock.
// state   | meaning
// S_MUTE  | no tone; waiting for a first rising edge to use as reference
// S_ARM   | reference edge seen; waiting for the first measurable period
// S_TRACK | periods being reported; lock tracking active
module tone_meter #(
    parameter logic [27:0] TIMEOUT    = 28'd2_500_000,
    parameter logic [27:0] MIN_PERIOD = 28'd16,
    parameter logic [27:0] TOLERANCE  = 28'd4,
    parameter logic [2:0]  LOCK_COUNT = 3'd3
) (
    input  logic        clock_in,
    input  logic        reset_n,
    input  logic        tone_in,
    output logic [27:0] period_out,
    output logic        period_valid,
    output logic        mute_out,
    output logic        locked
);

    typedef enum logic [1:0] {
        S_MUTE  = 2'd0,
        S_ARM   = 2'd1,
        S_TRACK = 2'd2
    } state_t;

    localparam logic [27:0] CNT_MAX = '1;

    state_t      state_q, state_d;
    logic        sync1_q, sync2_q, dly_q;
    logic [27:0] cnt_q, cnt_d;
    logic [27:0] period_q, period_d;
    logic [27:0] prev_q, prev_d;
    logic        valid_q, valid_d;
    logic        mute_q, mute_d;
    logic        locked_q, locked_d;
    logic [2:0]  match_q, match_d;
    logic [2:0]  match_inc;
    logic [27:0] captured, diff;
    logic        rise, accept, timeout;

    assign rise      = sync2_q & ~dly_q;
    assign captured  = cnt_q + 28'd1;
    assign diff      = (captured >= prev_q) ? (captured - prev_q) : (prev_q - captured);
    assign accept    = rise && (state_q != S_MUTE) && (captured >= MIN_PERIOD);
    assign timeout   = (state_q != S_MUTE) && (cnt_q == TIMEOUT - 28'd1);
    assign match_inc = (match_q == LOCK_COUNT) ? match_q : match_q + 3'd1;

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            dly_q    <= 1'b0;
            state_q  <= S_MUTE;
            cnt_q    <= '0;
            period_q <= '0;
            prev_q   <= '0;
            valid_q  <= 1'b0;
            mute_q   <= 1'b1;
            locked_q <= 1'b0;
            match_q  <= '0;
        end else begin
            sync1_q  <= tone_in;
            sync2_q  <= sync1_q;
            dly_q    <= sync2_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            prev_q   <= prev_d;
            valid_q  <= valid_d;
            mute_q   <= mute_d;
            locked_q <= locked_d;
            match_q  <= match_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 28'd1;
        period_d = period_q;
        prev_d   = prev_q;
        valid_d  = 1'b0;
        mute_d   = mute_q;
        locked_d = locked_q;
        match_d  = match_q;
        unique case (state_q)
            S_MUTE: begin
                if (rise) begin
                    state_d = S_ARM;
                    cnt_d   = '0;
                end
            end
            S_ARM, S_TRACK: begin
                // An accepted rise wins over a timeout landing in the same cycle.
                if (accept) begin
                    state_d  = S_TRACK;
                    cnt_d    = '0;
                    period_d = captured;
                    prev_d   = captured;
                    valid_d  = 1'b1;
                    mute_d   = 1'b0;
                    if (state_q == S_ARM) begin
                        match_d = '0;
                    end else if (diff <= TOLERANCE) begin
                        match_d = match_inc;
                        if (match_inc == LOCK_COUNT) locked_d = 1'b1;
                    end else begin
                        match_d  = '0;
                        locked_d = 1'b0;
                    end
                end else if (timeout) begin
                    state_d  = S_MUTE;
                    cnt_d    = '0;
                    period_d = '0;
                    mute_d   = 1'b1;
                    locked_d = 1'b0;
                    match_d  = '0;
                end
            end
            default: state_d = S_MUTE;
        endcase
    end

    assign period_out   = period_q;
    assign period_valid = valid_q;
    assign mute_out     = mute_q;
    assign locked       = locked_q;

endmodule

// File: tb/tb_tone_meter.sv
// Bench for tone_meter: a table of tone periods, hand-built corner sequences and random periods,
// all cross-checked every cycle against an edge-timestamp reference model.
module tb_tone_meter;

    localparam logic [27:0] TIMEOUT    = 28'd1000;
    localparam logic [27:0] MIN_PERIOD = 28'd8;
    localparam logic [27:0] TOLERANCE  = 28'd2;
    localparam logic [2:0]  LOCK_COUNT = 3'd3;
    localparam int          LAT        = 3;

    logic        clock_in = 1'b0;
    logic        reset_n  = 1'b0;
    logic        tone_in  = 1'b0;
    logic [27:0] period_out;
    logic        period_valid, mute_out, locked;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clock_in = ~clock_in;

    tone_meter #(
        .TIMEOUT   (TIMEOUT),
        .MIN_PERIOD(MIN_PERIOD),
        .TOLERANCE (TOLERANCE),
        .LOCK_COUNT(LOCK_COUNT)
    ) dut (
        .clock_in    (clock_in),
        .reset_n     (reset_n),
        .tone_in     (tone_in),
        .period_out  (period_out),
        .period_valid(period_valid),
        .mute_out    (mute_out),
        .locked      (locked)
    );

    // Reference model: works on timestamps of the edges at which each tone rise takes effect.
    int q_eff[$];
    bit m_ref, m_track;
    int ref_t, m_match, m_period, m_prev;
    bit m_valid, m_mute, m_locked;

    function automatic void model_reset();
        q_eff.delete();
        m_ref = 0; m_track = 0; ref_t = 0; m_match = 0;
        m_period = 0; m_prev = 0; m_valid = 0; m_mute = 1; m_locked = 0;
    endfunction

    function automatic void model_edge(input int t);
        int d, dd;
        m_valid = 0;
        if (q_eff.size() > 0 && q_eff[0] == t) begin
            void'(q_eff.pop_front());
            if (!m_ref) begin
                m_ref = 1;
                ref_t = t;
            end else begin
                d = t - ref_t;
                if (d >= int'(MIN_PERIOD)) begin
                    if (m_track) begin
                        dd = (d >= m_prev) ? d - m_prev : m_prev - d;
                        if (dd <= int'(TOLERANCE)) begin
                            if (m_match < int'(LOCK_COUNT)) m_match = m_match + 1;
                            if (m_match == int'(LOCK_COUNT)) m_locked = 1;
                        end else begin
                            m_match = 0;
                            m_locked = 0;
                        end
                    end
                    m_track = 1; m_period = d; m_prev = d;
                    m_valid = 1; m_mute = 0; ref_t = t;
                end
            end
        end else if (m_ref && (t - ref_t) == int'(TIMEOUT)) begin
            m_ref = 0; m_track = 0; m_match = 0;
            m_period = 0; m_mute = 1; m_locked = 0;
        end
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, got, exp);
        end
    endtask

    task automatic check_outputs();
        logic [30:0] got, exp;
        got = {period_out, period_valid, mute_out, locked};
        exp = {m_period[27:0], m_valid, m_mute, m_locked};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL model_cycle %0d: got period=%0d valid=%0b mute=%0b locked=%0b, expected period=%0d valid=%0b mute=%0b locked=%0b",
                     cyc, period_out, period_valid, mute_out, locked, m_period, m_valid, m_mute, m_locked);
        end
    endtask

    task automatic tick(input logic t);
        @(posedge clock_in);
        cyc++;
        model_edge(cyc);
        #1;
        if (t && !tone_in) q_eff.push_back(cyc + LAT);
        tone_in = t;
        @(negedge clock_in);
        check_outputs();
    endtask

    task automatic wave(input int per, input int hi);
        for (int i = 0; i < per; i++) tick(i < hi);
    endtask

    // One tone period starting with a rise; the rise's effect is checked against fixed values.
    task automatic wave_chk(input int per, input int hi, input string name, input int e_period,
                            input logic e_valid, input logic e_mute, input logic e_locked);
        for (int i = 0; i < per; i++) begin
            tick(i < hi);
            if (i == LAT) begin
                check({name, ".period"}, 32'(period_out), 32'(e_period));
                check({name, ".valid"},  32'(period_valid), 32'(e_valid));
                check({name, ".mute"},   32'(mute_out), 32'(e_mute));
                check({name, ".locked"}, 32'(locked), 32'(e_locked));
            end
        end
    endtask

    typedef struct {
        int   per;
        int   e_period;
        logic e_valid;
        logic e_mute;
        logic e_locked;
    } vec_t;

    vec_t tbl[11];
    int   acc_edge;

    initial begin
        tbl[0]  = '{100,   0, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{100, 100, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{100, 100, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{100, 100, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{101, 100, 1'b1, 1'b0, 1'b1};
        tbl[5]  = '{ 99, 101, 1'b1, 1'b0, 1'b1};
        tbl[6]  = '{103,  99, 1'b1, 1'b0, 1'b1};
        tbl[7]  = '{103, 103, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{103, 103, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{103, 103, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{100, 103, 1'b1, 1'b0, 1'b1};

        model_reset();
        repeat (3) @(negedge clock_in);
        check("reset.period", 32'(period_out), 32'd0);
        check("reset.valid",  32'(period_valid), 32'd0);
        check("reset.mute",   32'(mute_out), 32'd1);
        check("reset.locked", 32'(locked), 32'd0);
        #1 reset_n = 1'b1;
        repeat (10) tick(1'b0);

        // Steady tone and jitter
        for (int r = 0; r < 11; r++) begin
            wave_chk(tbl[r].per, tbl[r].per / 2, $sformatf("tbl%0d", r), tbl[r].e_period,
                     tbl[r].e_valid, tbl[r].e_mute, tbl[r].e_locked);
        end
        acc_edge = cyc - (100 - 1 - LAT);

        // Silence: mute exactly TIMEOUT edges after the last accepted rise
        for (int i = 0; i < int'(TIMEOUT) && cyc < acc_edge + int'(TIMEOUT) - 1; i++) tick(1'b0);
        check("silence.pre_mute",   32'(mute_out), 32'd0);
        check("silence.pre_locked", 32'(locked), 32'd1);
        tick(1'b0);
        check("silence.mute",   32'(mute_out), 32'd1);
        check("silence.period", 32'(period_out), 32'd0);
        check("silence.locked", 32'(locked), 32'd0);
        check("silence.valid",  32'(period_valid), 32'd0);
        repeat (20) tick(1'b0);
        wave_chk(100, 50, "rearm", 0, 1'b0, 1'b1, 1'b0);
        wave_chk(100, 50, "resume", 100, 1'b1, 1'b0, 1'b0);
        repeat (3) wave(100, 50);

        // Glitch: second rise 4 cycles after an accepted rise is ignored
        for (int i = 0; i < 100; i++) begin
            tick((i < 2) || (i >= 4 && i < 6));
            if (i == LAT) check("glitch.lock_before", 32'(locked), 32'd1);
            if (i == 4 + LAT) begin
                check("glitch.valid",  32'(period_valid), 32'd0);
                check("glitch.period", 32'(period_out), 32'd100);
                check("glitch.locked", 32'(locked), 32'd1);
            end
        end
        wave_chk(1000, 50, "after_glitch", 100, 1'b1, 1'b0, 1'b1);

        // Boundaries: period == TIMEOUT, period 7 ignored, period 8 accepted
        wave_chk(7, 3, "period_1000", 1000, 1'b1, 1'b0, 1'b0);
        wave_chk(93, 3, "period_7", 1000, 1'b0, 1'b0, 1'b0);
        wave_chk(8, 4, "after_7", 100, 1'b1, 1'b0, 1'b0);
        wave_chk(100, 50, "period_8", 8, 1'b1, 1'b0, 1'b0);
        repeat (4) wave(100, 50);

        // Mid-run reset while locked
        repeat (20) tick(1'b1);
        check("pre_reset.locked", 32'(locked), 32'd1);
        #2 reset_n = 1'b0;
        tone_in = 1'b0;
        #1;
        check("midreset.period", 32'(period_out), 32'd0);
        check("midreset.valid",  32'(period_valid), 32'd0);
        check("midreset.mute",   32'(mute_out), 32'd1);
        check("midreset.locked", 32'(locked), 32'd0);
        model_reset();
        repeat (3) @(posedge clock_in);
        @(negedge clock_in);
        #1 reset_n = 1'b1;
        repeat (50) tick(1'b0);
        check("idle_after_reset.mute", 32'(mute_out), 32'd1);

        // Random periods, including glitches and timeouts
        for (int r = 0; r < 40; r++) begin
            int per, hi;
            case ($urandom_range(0, 3))
                0:       per = $urandom_range(4, 12);
                1:       per = $urandom_range(95, 105);
                2:       per = $urandom_range(900, 1200);
                default: per = $urandom_range(13, 400);
            endcase
            hi = $urandom_range(2, per - 2);
            wave(per, hi);
        end
        repeat (1100) tick(1'b0);
        check("final.mute", 32'(mute_out), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
